// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and dispatch: a circular FIFO of predicted
// instructions with a one-cycle RECOVER bubble after a mispredict flush.
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_inst,
    input  logic [XLEN-1:0]          in_pred_npc,
    input  logic                     in_pred_taken,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic [XLEN-1:0]          out_pred_npc,
    output logic                     out_pred_taken,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    logic [0:0]      state;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] npc_mem  [DEPTH];
    logic            tkn_mem  [DEPTH];

    logic push;
    logic pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full  && (state == ST_RUN);
    assign out_valid = !empty && (state == ST_RUN);

    assign push = in_valid  && in_ready;
    assign pop  = out_valid && out_ready;

    assign out_pc         = pc_mem[head];
    assign out_inst       = inst_mem[head];
    assign out_pred_npc   = npc_mem[head];
    assign out_pred_taken = tkn_mem[head];

    // NOTE: entry storage has no reset; occupancy is tracked by count, so stale
    // contents are never presented as valid and the array maps to plain RAM.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            pc_mem[tail]   <= in_pc;
            inst_mem[tail] <= in_inst;
            npc_mem[tail]  <= in_pred_npc;
            tkn_mem[tail]  <= in_pred_taken;
        end
    end

    // Flush wins over push/pop in either state; RECOVER lasts until flush drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            state <= ST_RECOVER;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= ST_RUN;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: ordering, full/empty limits, flush recovery,
// predictor field passthrough and asynchronous reset.
module tb_inst_buffer;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [XLEN-1:0]   in_pc = '0;
    logic [31:0]       in_inst = '0;
    logic [XLEN-1:0]   in_pred_npc = '0;
    logic              in_pred_taken = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_inst;
    logic [XLEN-1:0]   out_pred_npc;
    logic              out_pred_taken;
    logic              out_ready = 1'b0;
    logic              flush = 1'b0;
    logic [3:0]        count;
    logic              full;
    logic              empty;

    int n_cmp = 0;
    int n_err = 0;

    inst_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_pred_npc    (in_pred_npc),
        .in_pred_taken  (in_pred_taken),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_pred_npc   (out_pred_npc),
        .out_pred_taken (out_pred_taken),
        .out_ready      (out_ready),
        .flush          (flush),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_entry(input logic [31:0] pc);
        in_pc         = pc;
        in_inst       = pc ^ 32'hA5A5_0000;
        in_pred_npc   = pc + 32'd4;
        in_pred_taken = pc[2];
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            drive_entry(base + 32'(4 * i));
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] exp_pc;
        int          pushed;
        int          popped;
        int          cyc;
        int          max_cnt;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_empty",     64'(empty),     64'd1);
        check("rst_full",      64'(full),      64'd0);
        check("rst_count",     64'(count),     64'd0);
        reset = 1'b1;
        step();
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // Three pushes, then in-order pops
        push_n(3, 32'h0);
        check("seq_count3", 64'(count), 64'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("seq_valid", 64'(out_valid), 64'd1);
            check("seq_pc",    64'(out_pc),    64'(4 * i));
            step();
        end
        out_ready = 1'b0;
        check("seq_empty", 64'(empty), 64'd1);

        // Fill, then pop with in_valid held: no full bypass
        push_n(DEPTH, 32'h200);
        check("full_flag",     64'(full),     64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_count",    64'(count),    64'd8);
        in_valid  = 1'b1;
        drive_entry(32'h100);
        out_ready = 1'b1;
        check("full_head_pc", 64'(out_pc), 64'h200);
        step();
        in_valid = 1'b0;
        check("full_count7",    64'(count),    64'd7);
        check("full_ready_ret", 64'(in_ready), 64'd1);
        for (int i = 1; i < DEPTH; i++) begin
            check("drain_pc", 64'(out_pc), 64'(32'h200 + 4 * i));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 64'(empty), 64'd1);

        // Random handshake across pointer wrap, scoreboarded
        pushed  = 0;
        popped  = 0;
        max_cnt = 0;
        cyc     = 0;
        while (popped < 12 && cyc < 300) begin
            in_valid  = (pushed < 12) && ($urandom_range(0, 1) == 1);
            drive_entry(32'h1000 + 32'(4 * pushed));
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            check("rnd_count",     64'(count),     64'(exp_q.size()));
            check("rnd_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check("rnd_pc",   64'(out_pc),   64'(exp_pc));
                check("rnd_inst", 64'(out_inst), 64'(exp_pc ^ 32'hA5A5_0000));
                popped++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_pc);
                pushed++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rnd_popped_all", 64'(popped), 64'd12);
        check("rnd_max_le8",    64'(max_cnt <= DEPTH), 64'd1);

        // Flush with simultaneous push and pop
        push_n(5, 32'h3000);
        check("fl_count5", 64'(count), 64'd5);
        in_valid  = 1'b1;
        drive_entry(32'h3100);
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        check("fl_count0",    64'(count),     64'd0);
        check("fl_in_ready",  64'(in_ready),  64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        step();
        check("fl_run_ready", 64'(in_ready), 64'd1);
        check("fl_no_push",   64'(count),    64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Flush held two cycles stays in RECOVER
        flush = 1'b1;
        step();
        step();
        check("fl2_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b0;
        step();
        check("fl2_run", 64'(in_ready), 64'd1);

        // Predictor fields passthrough, one-cycle latency
        in_valid      = 1'b1;
        in_pc         = 32'h40;
        in_inst       = 32'h0000_0013;
        in_pred_npc   = 32'h80;
        in_pred_taken = 1'b1;
        #1;
        check("pred_no_bypass", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        check("pred_valid", 64'(out_valid),      64'd1);
        check("pred_pc",    64'(out_pc),         64'h40);
        check("pred_npc",   64'(out_pred_npc),   64'h80);
        check("pred_taken", 64'(out_pred_taken), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle drops everything immediately
        push_n(4, 32'h5000);
        check("ar_count4", 64'(count), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_count",     64'(count),     64'd0);
        check("ar_empty",     64'(empty),     64'd1);
        #2;
        reset = 1'b1;
        step();
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_no_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter DEPTH, default 8, meaning the number of instruction entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter XLEN, default 32, meaning the PC and instruction width.
REQ-003 clock  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  is an asynchronous, active-low reset; all state SHALL clear immediately when reset is 0.
REQ-005 in_valid  input  1  means fetch presents an entry.
REQ-006 in_pc  input  XLEN  is the PC of the fetched instruction.
REQ-007 in_inst  input  32  is the fetched instruction word.
REQ-008 in_pred_npc  input  XLEN  is the predicted next PC from the branch predictor.
REQ-009 in_pred_taken  input  1  is the predictor taken flag.
REQ-010 in_ready  output  1  means the buffer accepts an entry this cycle.
REQ-011 out_valid  output  1  means the head entry is valid for dispatch.
REQ-012 out_pc, out_inst, out_pred_npc, out_pred_taken  output  XLEN/32/XLEN/1  carry the head entry fields.
REQ-013 out_ready  input  1  means dispatch consumes the head this cycle.
REQ-014 flush  input  1  is a mispredict squash from the execute stage.
REQ-015 count  output  $clog2(DEPTH)+1  is the number of occupied entries.
REQ-016 full and empty  output  1 each  are the occupancy flags.

Function
REQ-017 Storage SHALL be a circular FIFO with head and tail pointers of $clog2(DEPTH) bits each, wrapping from DEPTH-1 to 0.
REQ-018 A push SHALL occur when in_valid && in_ready; it writes all four fields at tail and then increments tail.
REQ-019 A pop SHALL occur when out_valid && out_ready; it increments head.
REQ-020 count SHALL update by +1 on push only, -1 on pop only, and SHALL stay unchanged on simultaneous push and pop.
REQ-021 full SHALL equal (count==DEPTH), empty SHALL equal (count==0), and out_valid SHALL equal !empty && state==RUN.
REQ-022 in_ready SHALL equal !full && state==RUN; there SHALL be no full-bypass, so in_ready is 0 when full even if a pop occurs that cycle.
REQ-023 There SHALL be no empty-bypass: an entry pushed at edge N SHALL first appear on out_* after edge N, giving 1-cycle latency.
REQ-024 out_* SHALL be read combinationally from the head entry; when empty, their values are don't-care.
REQ-025 FSM states SHALL be RUN and RECOVER.
REQ-026 In RUN, flush=1 SHALL cause the next edge to set head=tail=0 and count=0, discard any same-cycle push and pop, and enter RECOVER.
REQ-027 In RECOVER, in_ready and out_valid SHALL be 0; the next edge SHALL return to RUN unless flush=1, in which case the FSM stays in RECOVER.
REQ-028 flush SHALL take priority over push and pop in every state.
REQ-029 in_pred_taken SHALL NOT alter buffer behaviour; it is carried unchanged to dispatch.
REQ-030 The entry order out SHALL equal the accepted order in, with no loss or duplication across pointer wrap-around.

Reset
REQ-031 While reset=0, the block SHALL hold head=0, tail=0, count=0, state=RUN, out_valid=0, empty=1, and full=0.
REQ-032 After reset, in_ready SHALL be 1.
REQ-033 Entry storage contents SHALL NOT require reset.
REQ-034 Reset asserted mid-operation SHALL drop all entries without producing any spurious out_valid.

Verification
REQ-035 Reset, then push pc=0x0,0x4,0x8 on three consecutive cycles with out_ready=0 -> count=3; then out_ready=1 -> pc 0x0,0x4,0x8 pop in order, then empty=1.
REQ-036 Fill with DEPTH=8 entries -> full=1 and in_ready=0; hold in_valid=1 with out_ready=1 for 1 cycle -> count=7 and no push; next cycle in_ready=1.
REQ-037 Push 12 entries and pop 12 entries with randomized in_valid/out_ready -> output sequence equals input sequence across the wrap, and count never exceeds 8.
REQ-038 With count=5, assert flush alongside push and pop -> next cycle count=0 and state=RECOVER with in_ready=0 and out_valid=0; the cycle after that, state=RUN and in_ready=1.
REQ-039 Push entry pc=0x40, npc=0x80, taken=1 -> out_pred_npc=0x80 and out_pred_taken=1 appear one cycle later.
REQ-040 Drive reset=0 asynchronously mid-cycle with count=4 -> out_valid=0 and count=0 immediately, before the next clock edge.
